// File: rtl/time_keeper_pkg.sv
// rtl/time_keeper_pkg.sv - shared types and constants for the BCD time keeper
package time_keeper_pkg;

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } state_t;

    typedef logic [7:0] bcd2_t;

    localparam bcd2_t MAX_SEC = 8'h59;
    localparam bcd2_t MAX_MIN = 8'h59;

    // Elaboration-time only: turns a decimal parameter into its BCD limit constant.
    function automatic bcd2_t dec_to_bcd2(input int unsigned v);
        bcd2_t r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - two-digit BCD counter that wraps from MAX to 00
module bcd_mod_counter
    import time_keeper_pkg::*;
#(
    parameter bcd2_t MAX = 8'h59
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  inc,
    input  logic  clr,
    output bcd2_t value,
    output logic  max_reached,
    output logic  wrap
);

    bcd2_t inc_val;

    // Native BCD step: units roll 9->0 and carry into tens.
    always_comb begin
        inc_val = value;
        if (value[3:0] == 4'd9) begin
            inc_val = {value[7:4] + 4'd1, 4'd0};
        end else begin
            inc_val[3:0] = value[3:0] + 4'd1;
        end
    end

    assign max_reached = (value == MAX);
    assign wrap        = inc & max_reached;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= 8'h00;
        end else if (clr) begin
            value <= 8'h00;
        end else if (inc) begin
            value <= max_reached ? 8'h00 : inc_val;
        end
    end

endmodule

// File: rtl/time_keeper.sv
// rtl/time_keeper.sv - BCD hh:mm:ss clock with run/stop FSM; optional alarm via TIME_KEEPER_ALARM_EN
module time_keeper
    import time_keeper_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOUR_MAX    = 23
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       slow_clk,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       inc_min,
    input  logic       inc_hour,
`ifdef TIME_KEEPER_ALARM_EN
    input  logic [7:0] alarm_hour_bcd,
    input  logic [7:0] alarm_min_bcd,
    output logic       alarm,
`endif
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] hour_bcd,
    output logic       running,
    output logic       sec_tick
);

    localparam int    ARM_CYCLES = SYNC_STAGES + 1;
    localparam bcd2_t MAX_HOUR   = dec_to_bcd2(HOUR_MAX);

    state_t                 state, state_next;
    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic                   edge_r;
    logic [2:0]             arm_cnt;
    logic                   armed;
    logic                   tick;
    logic                   adj_ok;
    logic                   sec_inc, min_inc, hour_inc;
    logic                   sec_max, min_max, hour_max;
    logic                   sec_wrap, min_wrap, hour_wrap;
    logic                   sec_tick_r;
    logic                   unused_ok;

    assign armed = (arm_cnt == 3'(ARM_CYCLES));

    // Edge is registered once more so the update lands SYNC_STAGES+1 cycles after sampling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync    <= '0;
            prev    <= 1'b0;
            edge_r  <= 1'b0;
            arm_cnt <= 3'd0;
        end else begin
            sync    <= {sync[SYNC_STAGES-2:0], slow_clk};
            prev    <= sync[SYNC_STAGES-1];
            edge_r  <= sync[SYNC_STAGES-1] & ~prev & armed;
            if (!armed) begin
                arm_cnt <= arm_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= STOPPED;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (start_stop) begin
            state_next = (state == STOPPED) ? RUNNING : STOPPED;
        end
    end

    always_comb begin
        running = (state == RUNNING);
    end

    // Tick is judged on the pre-toggle state; manual adjust only while stopped.
    assign tick     = edge_r & running;
    assign adj_ok   = ~running;
    assign sec_inc  = tick;
    assign min_inc  = (tick & sec_wrap) | (adj_ok & inc_min);
    assign hour_inc = (tick & min_wrap) | (adj_ok & inc_hour);

    bcd_mod_counter #(.MAX(MAX_SEC)) u_sec (
        .clk         (clk),
        .rst_n       (rst_n),
        .inc         (sec_inc),
        .clr         (clear),
        .value       (sec_bcd),
        .max_reached (sec_max),
        .wrap        (sec_wrap)
    );

    bcd_mod_counter #(.MAX(MAX_MIN)) u_min (
        .clk         (clk),
        .rst_n       (rst_n),
        .inc         (min_inc),
        .clr         (clear),
        .value       (min_bcd),
        .max_reached (min_max),
        .wrap        (min_wrap)
    );

    bcd_mod_counter #(.MAX(MAX_HOUR)) u_hour (
        .clk         (clk),
        .rst_n       (rst_n),
        .inc         (hour_inc),
        .clr         (clear),
        .value       (hour_bcd),
        .max_reached (hour_max),
        .wrap        (hour_wrap)
    );

    assign unused_ok = ^{sec_max, min_max, hour_max, hour_wrap};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_tick_r <= 1'b0;
        end else begin
            sec_tick_r <= tick & ~clear;
        end
    end

    assign sec_tick = sec_tick_r;

`ifdef TIME_KEEPER_ALARM_EN
    // Fires on the cycle after a tick lands exactly on hh:mm:00.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm <= 1'b0;
        end else if (clear || start_stop) begin
            alarm <= 1'b0;
        end else if (sec_tick_r && running && sec_bcd == 8'h00 &&
                     min_bcd == alarm_min_bcd && hour_bcd == alarm_hour_bcd) begin
            alarm <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_time_keeper.sv
// tb/tb_time_keeper.sv - directed self-checking bench for time_keeper
module tb_time_keeper;

    logic       clk = 1'b0;
    logic       rst_n, slow_clk, start_stop, clear, inc_min, inc_hour;
    logic [7:0] sec_bcd, min_bcd, hour_bcd;
    logic       running, sec_tick;
`ifdef TIME_KEEPER_ALARM_EN
    logic [7:0] alarm_hour_bcd, alarm_min_bcd;
    logic       alarm;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    time_keeper #(.SYNC_STAGES(2), .HOUR_MAX(23)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .slow_clk       (slow_clk),
        .start_stop     (start_stop),
        .clear          (clear),
        .inc_min        (inc_min),
        .inc_hour       (inc_hour),
`ifdef TIME_KEEPER_ALARM_EN
        .alarm_hour_bcd (alarm_hour_bcd),
        .alarm_min_bcd  (alarm_min_bcd),
        .alarm          (alarm),
`endif
        .sec_bcd        (sec_bcd),
        .min_bcd        (min_bcd),
        .hour_bcd       (hour_bcd),
        .running        (running),
        .sec_tick       (sec_tick)
    );

    task pulse_ss();
        start_stop = 1'b1;
        @(negedge clk);
        start_stop = 1'b0;
    endtask

    task pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task pulse_inc(input logic m, input logic h);
        inc_min  = m;
        inc_hour = h;
        @(negedge clk);
        inc_min  = 1'b0;
        inc_hour = 1'b0;
    endtask

    // Raises slow_clk, optionally clears in the update cycle, reports sec_tick there.
    task do_tick(input logic with_clear, output logic seen);
        slow_clk = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        clear = with_clear;
        @(negedge clk);
        seen  = sec_tick;
        clear = 1'b0;
        slow_clk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task test_reset();
        n_cmp++; if (sec_bcd !== 8'h00) begin n_bad++; $display("FAIL reset_sec got %h want 00", sec_bcd); end
        n_cmp++; if (min_bcd !== 8'h00) begin n_bad++; $display("FAIL reset_min got %h want 00", min_bcd); end
        n_cmp++; if (hour_bcd !== 8'h00) begin n_bad++; $display("FAIL reset_hour got %h want 00", hour_bcd); end
        n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL reset_running got %b want 0", running); end
        n_cmp++; if (sec_tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick got %b want 0", sec_tick); end
        rst_n = 1'b1;
        pulse_ss();
        n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL start_running got %b want 1", running); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++; if (sec_tick !== 1'b0) begin n_bad++; $display("FAIL disarm_tick cycle %0d got %b want 0", i, sec_tick); end
        end
        n_cmp++; if ({hour_bcd, min_bcd, sec_bcd} !== 24'h000000) begin n_bad++; $display("FAIL disarm_time got %h want 000000", {hour_bcd, min_bcd, sec_bcd}); end
        slow_clk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task test_tick_latency();
        slow_clk = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (sec_tick !== 1'b0 || sec_bcd !== 8'h00) begin n_bad++; $display("FAIL lat_early got tick=%b sec=%h want tick=0 sec=00", sec_tick, sec_bcd); end
        @(negedge clk);
        n_cmp++; if (sec_tick !== 1'b1 || sec_bcd !== 8'h01) begin n_bad++; $display("FAIL lat_n3 got tick=%b sec=%h want tick=1 sec=01", sec_tick, sec_bcd); end
        @(negedge clk);
        n_cmp++; if (sec_tick !== 1'b0 || sec_bcd !== 8'h01) begin n_bad++; $display("FAIL lat_pulse got tick=%b sec=%h want tick=0 sec=01", sec_tick, sec_bcd); end
        slow_clk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task test_stopped_discard();
        logic seen;
        pulse_ss();
        n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL stop_running got %b want 0", running); end
        do_tick(1'b0, seen);
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL stop_tick got %b want 0", seen); end
        n_cmp++; if (sec_bcd !== 8'h01) begin n_bad++; $display("FAIL stop_sec got %h want 01", sec_bcd); end
    endtask

    task test_inc_min();
        pulse_clear();
        pulse_inc(1'b0, 1'b1);
        n_cmp++; if (hour_bcd !== 8'h01) begin n_bad++; $display("FAIL inc_hour1 got %h want 01", hour_bcd); end
        for (int i = 0; i < 60; i++) pulse_inc(1'b1, 1'b0);
        n_cmp++; if (min_bcd !== 8'h00) begin n_bad++; $display("FAIL min_wrap got %h want 00", min_bcd); end
        n_cmp++; if (hour_bcd !== 8'h01) begin n_bad++; $display("FAIL min_nocarry got %h want 01", hour_bcd); end
        n_cmp++; if (sec_bcd !== 8'h00) begin n_bad++; $display("FAIL min_sec got %h want 00", sec_bcd); end
        pulse_inc(1'b1, 1'b1);
        n_cmp++; if ({hour_bcd, min_bcd} !== 16'h0201) begin n_bad++; $display("FAIL inc_both got %h want 0201", {hour_bcd, min_bcd}); end
        pulse_ss();
        pulse_inc(1'b1, 1'b1);
        n_cmp++; if ({hour_bcd, min_bcd} !== 16'h0201) begin n_bad++; $display("FAIL inc_running got %h want 0201", {hour_bcd, min_bcd}); end
        pulse_ss();
    endtask

    task test_full_wrap();
        logic seen;
        pulse_clear();
        for (int i = 0; i < 23; i++) pulse_inc(1'b0, 1'b1);
        n_cmp++; if (hour_bcd !== 8'h23) begin n_bad++; $display("FAIL hour_23 got %h want 23", hour_bcd); end
        pulse_inc(1'b0, 1'b1);
        n_cmp++; if (hour_bcd !== 8'h00) begin n_bad++; $display("FAIL hour_wrap got %h want 00", hour_bcd); end
        for (int i = 0; i < 23; i++) pulse_inc(1'b0, 1'b1);
        for (int i = 0; i < 59; i++) pulse_inc(1'b1, 1'b0);
        pulse_ss();
        for (int i = 0; i < 59; i++) do_tick(1'b0, seen);
        n_cmp++; if ({hour_bcd, min_bcd, sec_bcd} !== 24'h235959) begin n_bad++; $display("FAIL preload got %h want 235959", {hour_bcd, min_bcd, sec_bcd}); end
        do_tick(1'b0, seen);
        n_cmp++; if ({hour_bcd, min_bcd, sec_bcd} !== 24'h000000) begin n_bad++; $display("FAIL day_wrap got %h want 000000", {hour_bcd, min_bcd, sec_bcd}); end
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL day_wrap_tick got %b want 1", seen); end
    endtask

    task test_clear_tick();
        logic seen;
        for (int i = 0; i < 9; i++) do_tick(1'b0, seen);
        n_cmp++; if (sec_bcd !== 8'h09) begin n_bad++; $display("FAIL nine_sec got %h want 09", sec_bcd); end
        do_tick(1'b1, seen);
        n_cmp++; if ({hour_bcd, min_bcd, sec_bcd} !== 24'h000000) begin n_bad++; $display("FAIL clr_tick_time got %h want 000000", {hour_bcd, min_bcd, sec_bcd}); end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL clr_tick_pulse got %b want 0", seen); end
        n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL clr_tick_running got %b want 1", running); end
    endtask

`ifdef TIME_KEEPER_ALARM_EN
    task test_alarm();
        logic seen;
        for (int i = 0; i < 59; i++) do_tick(1'b0, seen);
        n_cmp++; if (alarm !== 1'b0) begin n_bad++; $display("FAIL alarm_early got %b want 0", alarm); end
        do_tick(1'b0, seen);
        n_cmp++; if (alarm !== 1'b1) begin n_bad++; $display("FAIL alarm_set got %b want 1", alarm); end
        pulse_ss();
        n_cmp++; if (alarm !== 1'b0) begin n_bad++; $display("FAIL alarm_clr got %b want 0", alarm); end
        pulse_ss();
    endtask
`endif

    task test_reset_mid();
        logic seen;
        do_tick(1'b0, seen);
        do_tick(1'b0, seen);
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({hour_bcd, min_bcd, sec_bcd} !== 24'h000000) begin n_bad++; $display("FAIL mid_reset_time got %h want 000000", {hour_bcd, min_bcd, sec_bcd}); end
        n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL mid_reset_running got %b want 0", running); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        pulse_ss();
        do_tick(1'b0, seen);
        n_cmp++; if (sec_bcd !== 8'h01 || seen !== 1'b1) begin n_bad++; $display("FAIL no_resume got sec=%h tick=%b want sec=01 tick=1", sec_bcd, seen); end
    endtask

    initial begin
        rst_n = 1'b0; slow_clk = 1'b1; start_stop = 1'b0; clear = 1'b0;
        inc_min = 1'b0; inc_hour = 1'b0;
`ifdef TIME_KEEPER_ALARM_EN
        alarm_hour_bcd = 8'h00; alarm_min_bcd = 8'h01;
`endif
        repeat (3) @(negedge clk);
        test_reset();
        test_tick_latency();
        test_stopped_discard();
        test_inc_min();
        test_full_wrap();
        test_clear_tick();
`ifdef TIME_KEEPER_ALARM_EN
        test_alarm();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/time_keeper.md
TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of flip-flops synchronising slow_clk into the clk domain (legal 2..4).
REQ-002 SHALL have parameter HOUR_MAX, default 23, meaning the last hour value before the hour wraps to 00 (legal 11 or 23).
REQ-003 SHALL have port clk, input, 1 bit: the 100 MHz system clock; all state is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port slow_clk, input, 1 bit: the 1 Hz divided square wave, treated as asynchronous data.
REQ-006 SHALL have port start_stop, input, 1 bit: a one-cycle pulse that toggles between RUNNING and STOPPED.
REQ-007 SHALL have port clear, input, 1 bit: a one-cycle pulse that zeroes the time.
REQ-008 SHALL have port inc_min, input, 1 bit: a one-cycle pulse that adds one minute, honoured only in STOPPED.
REQ-009 SHALL have port inc_hour, input, 1 bit: a one-cycle pulse that adds one hour, honoured only in STOPPED.
REQ-010 SHALL have port sec_bcd, output, 8 bits: two-digit BCD seconds, 00..59.
REQ-011 SHALL have port min_bcd, output, 8 bits: two-digit BCD minutes, 00..59.
REQ-012 SHALL have port hour_bcd, output, 8 bits: two-digit BCD hours, 00..HOUR_MAX.
REQ-013 SHALL have port running, output, 1 bit: high while in the RUNNING state.
REQ-014 SHALL have port sec_tick, output, 1 bit: a one-cycle pulse in the cycle sec_bcd advances.

Function
REQ-015 The FSM SHALL have exactly two states, STOPPED and RUNNING, with transitions as follows.
- STOPPED to RUNNING, and RUNNING to STOPPED, on a start_stop pulse.
- No other transitions.
REQ-016 slow_clk SHALL pass through SYNC_STAGES flops; a rising edge SHALL be detected by comparing the last synchroniser flop with one further flop.
REQ-017 A detected edge in RUNNING SHALL increment the time and pulse sec_tick in the same cycle as the counters update.
- Latency from the first clk edge sampling slow_clk high to the counter update is SYNC_STAGES+1 cycles.
REQ-018 A detected edge in STOPPED SHALL be discarded, with no update and no sec_tick.
REQ-019 Seconds SHALL wrap 59 to 00 and carry one minute; minutes SHALL wrap 59 to 00 and carry one hour; hours SHALL wrap HOUR_MAX to 00 with no further carry.
REQ-020 A time of HOUR_MAX:59:59 followed by a tick SHALL give 00:00:00, with sec_tick high.
REQ-021 inc_min SHALL wrap 59 to 00 without carrying into the hour; inc_hour SHALL wrap HOUR_MAX to 00; seconds SHALL be unchanged by either.
REQ-022 Every BCD digit SHALL stay within 0..9 at all times; binary-to-BCD conversion is forbidden, and counting SHALL be done natively in BCD.
REQ-023 Priority for simultaneous events in one cycle SHALL be clear, then tick, then inc_hour/inc_min, then start_stop.
- A tick and start_stop arriving together SHALL be judged against the state held before the toggle.
REQ-024 clear SHALL zero the time in either state, leave the FSM state unchanged, and suppress any sec_tick in that cycle.
REQ-025 inc_min and inc_hour asserted together in STOPPED SHALL both apply.

Reset
REQ-026 While rst_n is low, the outputs SHALL hold these values:
- sec_bcd, min_bcd, hour_bcd = 8'h00
- running = 0
- sec_tick = 0
- FSM = STOPPED
- all synchroniser and edge flops = 0
REQ-027 Edge detection SHALL be disarmed for SYNC_STAGES+1 cycles after rst_n deasserts, so that a slow_clk already high at release produces no tick.
REQ-028 Asserting reset mid-count SHALL abandon the count immediately; there is no resume.

Configuration
REQ-029 With macro TIME_KEEPER_ALARM_EN defined, the block SHALL add two inputs and one output.
- Inputs alarm_hour_bcd[7:0] and alarm_min_bcd[7:0].
- Output alarm, a registered signal set when the time reaches alarm_hour:alarm_min:00 in RUNNING.
- alarm SHALL be cleared by start_stop, by clear, or by reset.
REQ-030 Without TIME_KEEPER_ALARM_EN, those ports and all alarm logic SHALL be absent.

Structure
REQ-031 Package time_keeper_pkg SHALL hold the following:
- the state enum (STOPPED, RUNNING)
- the bcd2_t 8-bit typedef
- the constants MAX_SEC=8'h59 and MAX_MIN=8'h59
REQ-032 Sub-module bcd_mod_counter SHALL implement a two-digit BCD counter with a parameterised max value.
- Ports: inc, clr, max reached, wrap.
- Instantiated three times: seconds, minutes and hours.

Verification
REQ-033 Reset release with slow_clk high, then 10 cycles -> sec_tick stays 0 and the time stays 00:00:00.
REQ-034 start_stop, then a slow_clk rising edge at cycle N -> sec_bcd=8'h01 and sec_tick=1 at cycle N+3 (SYNC_STAGES=2).
REQ-035 Preload 23:59:59 via inc pulses plus ticks, then one tick -> 00:00:00 with sec_tick=1.
REQ-036 STOPPED, 60 inc_min pulses -> min_bcd=8'h00 and hour_bcd unchanged; an inc_min while RUNNING -> no change.
REQ-037 clear and a tick in the same cycle at 00:00:09 -> 00:00:00, sec_tick=0, running still 1.
REQ-038 With TIME_KEEPER_ALARM_EN and alarm set to 8'h00:8'h01, run from 00:00:59 and tick -> alarm=1; a start_stop pulse -> alarm=0.
